// File: rtl/mem_mgr_pkg.sv
// Shared definitions for the memory-manager NoC response path:
// NoC message codes, encoder state encoding and reply-header field positions.
// The header helper packs
// {3'b000, hl, code, 7'h00, offset[11:0], dst_xy[5:0]} into one 32-bit word.
package mem_mgr_pkg;

  localparam logic [2:0] NOC_MACK   = 3'd1;
  localparam logic [2:0] NOC_MDATA  = 3'd2;
  localparam logic [2:0] NOC_MPUT   = 3'd4;
  localparam logic [2:0] NOC_MGET   = 3'd5;
  localparam logic [2:0] NOC_MLOAD  = 3'd6;
  localparam logic [2:0] NOC_MSTORE = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_ADDR,
    ST_DATA,
    ST_ACK
  } enc_state_e;

  localparam int HDR_XY_LSB   = 0;
  localparam int HDR_XY_W     = 6;
  localparam int HDR_OFF_LSB  = 6;
  localparam int HDR_OFF_W    = 12;
  localparam int HDR_CODE_LSB = 25;
  localparam int HDR_HL_BIT   = 28;

  function automatic logic [31:0] build_hdr(input logic                 hl,
                                            input logic [2:0]           code,
                                            input logic [HDR_OFF_W-1:0] offset,
                                            input logic [HDR_XY_W-1:0]  xy);
    logic [31:0] hdr;
    hdr                              = '0;
    hdr[HDR_HL_BIT]                  = hl;
    hdr[HDR_CODE_LSB +: 3]           = code;
    hdr[HDR_OFF_LSB +: HDR_OFF_W]    = offset;
    hdr[HDR_XY_LSB +: HDR_XY_W]      = xy;
    return hdr;
  endfunction

endpackage

// File: rtl/mem_mgr_resp_fifo.sv
// Synchronous FIFO buffering cache read responses until the encoder drains
// them.  Pointers carry one extra wrap bit to tell full from empty.
// Ports: clk/rst (sync, active-high), push/wdata, pop/rdata (head, show-ahead),
// full, empty.  Push is ignored when full, pop is ignored when empty.
module mem_mgr_resp_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata = mem_q[rd_q[AW-1:0]];

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push && !full) begin
      mem_d[wr_q[AW-1:0]] = wdata;
      wr_d                = wr_q + PTR_ONE;
    end
    if (pop && !empty) begin
      rd_d = rd_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage needs no reset: flushing the pointers empties the FIFO.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mem_mgr_noc_encoder.sv
// Reply encoder of the DRAM-tile memory manager.  Turns decoded request
// descriptors into NoC reply packets on an AXI-Stream master:
// MDATA for MLOAD/MGET, MACK for MSTORE, nothing for MPUT.  Cache read data
// is buffered in mem_mgr_resp_fifo so stream back-pressure never stalls
// the cache.
// Ports: clk_ctrl / clk_ctrl_rst_high (sync, active-high); cmd_* descriptor
// handshake; cpu_resp_* cache data input; stream_out_* AXI-Stream master;
// err_id sticky ID-mismatch flag.
// Optional build macro MEM_MGR_ENC_ID_CHECK_EN: stores the descriptor ID,
// widens the FIFO with cpu_resp_id and flags mismatches on err_id.  Without
// it err_id is tied 0.
//
// state   | meaning
// IDLE    | waiting for a descriptor (cmd_ready=1)
// HDR     | driving the reply header word
// ADDR    | driving the return address (long replies)
// DATA    | forwarding FIFO words, TLAST on the final one
// ACK     | driving the zero MACK payload with TLAST
module mem_mgr_noc_encoder
  import mem_mgr_pkg::*;
#(
  parameter int S_AXI_ID_SZ     = 11,
  parameter int LEN_SZ          = 16,
  parameter int OFFSET_SZ       = 12,
  parameter int XY_SZ           = 6,
  parameter int RESP_FIFO_DEPTH = 8
) (
  input  logic                   clk_ctrl,
  input  logic                   clk_ctrl_rst_high,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_code,
  input  logic                   cmd_hl,
  input  logic [XY_SZ-1:0]       cmd_src_xy,
  input  logic [OFFSET_SZ-1:0]   cmd_offset,
  input  logic [31:0]            cmd_ret_addr,
  input  logic [LEN_SZ-1:0]      cmd_len,
  input  logic [S_AXI_ID_SZ-1:0] cmd_id,
  input  logic                   cpu_resp_valid,
  input  logic [31:0]            cpu_resp_data,
  input  logic [S_AXI_ID_SZ-1:0] cpu_resp_id,
  output logic                   cpu_resp_ready,
  output logic                   stream_out_TVALID,
  output logic [31:0]            stream_out_TDATA,
  output logic [3:0]             stream_out_TKEEP,
  output logic                   stream_out_TLAST,
  input  logic                   stream_out_TREADY,
  output logic                   err_id
);

`ifdef MEM_MGR_ENC_ID_CHECK_EN
  localparam int FIFO_W = 32 + S_AXI_ID_SZ;
`else
  localparam int FIFO_W = 32;
`endif
  localparam logic [LEN_SZ-1:0] LEN_ONE = {{(LEN_SZ-1){1'b0}}, 1'b1};

  enc_state_e           state_q, state_d;
  logic                 hl_q, hl_d;
  logic [2:0]           code_q, code_d;
  logic [XY_SZ-1:0]     xy_q, xy_d;
  logic [OFFSET_SZ-1:0] off_q, off_d;
  logic [31:0]          addr_q, addr_d;
  logic [LEN_SZ-1:0]    cnt_q, cnt_d;

  logic [FIFO_W-1:0]    fifo_wdata, fifo_rdata;
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;

  // Held low during reset so every output except cmd_ready reads 0.
  assign cpu_resp_ready = !fifo_full && !clk_ctrl_rst_high;
  assign fifo_push      = cpu_resp_valid && cpu_resp_ready;

`ifdef MEM_MGR_ENC_ID_CHECK_EN
  assign fifo_wdata = {cpu_resp_id, cpu_resp_data};
`else
  assign fifo_wdata = cpu_resp_data;
`endif

  mem_mgr_resp_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (RESP_FIFO_DEPTH)
  ) u_resp_fifo (
    .clk   (clk_ctrl),
    .rst   (clk_ctrl_rst_high),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d           = state_q;
    hl_d              = hl_q;
    code_d            = code_q;
    xy_d              = xy_q;
    off_d             = off_q;
    addr_d            = addr_q;
    cnt_d             = cnt_q;
    cmd_ready         = 1'b0;
    fifo_pop          = 1'b0;
    stream_out_TVALID = 1'b0;
    stream_out_TDATA  = '0;
    stream_out_TLAST  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          hl_d   = cmd_hl;
          xy_d   = cmd_src_xy;
          off_d  = cmd_offset;
          addr_d = cmd_ret_addr;
          case (cmd_code)
            NOC_MSTORE: begin
              code_d  = NOC_MACK;
              state_d = ST_HDR;
            end
            NOC_MLOAD, NOC_MGET: begin
              code_d  = NOC_MDATA;
              // Short replies carry one word; a zero length means one word.
              cnt_d   = (!cmd_hl || cmd_len == '0) ? LEN_ONE : cmd_len;
              state_d = ST_HDR;
            end
            default: ;  // MPUT and unknown codes produce no reply
          endcase
        end
      end
      ST_HDR: begin
        stream_out_TVALID = 1'b1;
        stream_out_TDATA  = build_hdr(hl_q, code_q, HDR_OFF_W'(off_q), HDR_XY_W'(xy_q));
        if (stream_out_TREADY) begin
          if (hl_q)                  state_d = ST_ADDR;
          else if (code_q == NOC_MACK) state_d = ST_ACK;
          else                       state_d = ST_DATA;
        end
      end
      ST_ADDR: begin
        stream_out_TVALID = 1'b1;
        stream_out_TDATA  = addr_q;
        if (stream_out_TREADY) begin
          state_d = (code_q == NOC_MACK) ? ST_ACK : ST_DATA;
        end
      end
      ST_DATA: begin
        stream_out_TVALID = !fifo_empty;
        stream_out_TDATA  = fifo_rdata[31:0];
        stream_out_TLAST  = (cnt_q == LEN_ONE);
        if (!fifo_empty && stream_out_TREADY) begin
          fifo_pop = 1'b1;
          cnt_d    = (cnt_q != '0) ? cnt_q - LEN_ONE : '0;
          if (cnt_q == LEN_ONE) state_d = ST_IDLE;
        end
      end
      ST_ACK: begin
        stream_out_TVALID = 1'b1;
        stream_out_TLAST  = 1'b1;
        if (stream_out_TREADY) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    stream_out_TKEEP = {4{stream_out_TVALID}};
  end

  always_ff @(posedge clk_ctrl) begin
    if (clk_ctrl_rst_high) begin
      state_q <= ST_IDLE;
      hl_q    <= 1'b0;
      code_q  <= '0;
      xy_q    <= '0;
      off_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hl_q    <= hl_d;
      code_q  <= code_d;
      xy_q    <= xy_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef MEM_MGR_ENC_ID_CHECK_EN
  logic [S_AXI_ID_SZ-1:0] id_q, id_d;
  logic                   err_q, err_d;

  always_comb begin
    id_d  = id_q;
    err_d = err_q;
    if (state_q == ST_IDLE && cmd_valid) id_d = cmd_id;
    if (fifo_pop && fifo_rdata[32 +: S_AXI_ID_SZ] != id_q) err_d = 1'b1;
  end

  always_ff @(posedge clk_ctrl) begin
    if (clk_ctrl_rst_high) begin
      id_q  <= '0;
      err_q <= 1'b0;
    end else begin
      id_q  <= id_d;
      err_q <= err_d;
    end
  end

  assign err_id = err_q;
`else
  logic unused_id;
  assign unused_id = ^{cmd_id, cpu_resp_id};
  assign err_id    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_mgr_noc_encoder.sv
module tb_mem_mgr_noc_encoder;

  logic        clk_ctrl = 1'b0;
  logic        clk_ctrl_rst_high = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_code = '0;
  logic        cmd_hl = 1'b0;
  logic [5:0]  cmd_src_xy = '0;
  logic [11:0] cmd_offset = '0;
  logic [31:0] cmd_ret_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [10:0] cmd_id = '0;
  logic        cpu_resp_valid = 1'b0;
  logic [31:0] cpu_resp_data = '0;
  logic [10:0] cpu_resp_id = '0;
  logic        cpu_resp_ready;
  logic        stream_out_TVALID;
  logic [31:0] stream_out_TDATA;
  logic [3:0]  stream_out_TKEEP;
  logic        stream_out_TLAST;
  logic        stream_out_TREADY = 1'b0;
  logic        err_id;

  mem_mgr_noc_encoder dut (
    .clk_ctrl          (clk_ctrl),
    .clk_ctrl_rst_high (clk_ctrl_rst_high),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_code          (cmd_code),
    .cmd_hl            (cmd_hl),
    .cmd_src_xy        (cmd_src_xy),
    .cmd_offset        (cmd_offset),
    .cmd_ret_addr      (cmd_ret_addr),
    .cmd_len           (cmd_len),
    .cmd_id            (cmd_id),
    .cpu_resp_valid    (cpu_resp_valid),
    .cpu_resp_data     (cpu_resp_data),
    .cpu_resp_id       (cpu_resp_id),
    .cpu_resp_ready    (cpu_resp_ready),
    .stream_out_TVALID (stream_out_TVALID),
    .stream_out_TDATA  (stream_out_TDATA),
    .stream_out_TKEEP  (stream_out_TKEEP),
    .stream_out_TLAST  (stream_out_TLAST),
    .stream_out_TREADY (stream_out_TREADY),
    .err_id            (err_id)
  );

  always #5 clk_ctrl = ~clk_ctrl;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          n_beats = 0;
  logic        stall = 1'b0;
  logic [31:0] held_data = '0;
  logic        held_last = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_beat(input logic [31:0] data, input logic last);
    beat_t b;
    b.data = data;
    b.last = last;
    exp_q.push_back(b);
  endtask

  // Monitor: a beat seen valid&ready at the falling edge completes on the
  // next rising edge; stalled beats must hold until accepted.
  always @(negedge clk_ctrl) begin
    beat_t b;
    if (clk_ctrl_rst_high) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        check("hold_tvalid", 32'(stream_out_TVALID), 32'd1);
        check("hold_tdata", stream_out_TDATA, held_data);
        check("hold_tlast", 32'(stream_out_TLAST), 32'(held_last));
      end
      if (stream_out_TVALID) begin
        check("tkeep", 32'(stream_out_TKEEP), 32'hF);
        if (stream_out_TREADY) begin
          n_beats++;
          stall = 1'b0;
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got %h expected no beat", stream_out_TDATA);
          end else begin
            b = exp_q.pop_front();
            check("tdata", stream_out_TDATA, b.data);
            check("tlast", 32'(stream_out_TLAST), 32'(b.last));
          end
        end else begin
          stall     = 1'b1;
          held_data = stream_out_TDATA;
          held_last = stream_out_TLAST;
        end
      end else begin
        stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk_ctrl);
    #1;
  endtask

  task automatic send_cmd(input logic [2:0] code, input logic hl, input logic [5:0] xy,
                          input logic [11:0] off, input logic [31:0] addr,
                          input logic [15:0] len, input logic [10:0] id);
    cmd_valid    = 1'b1;
    cmd_code     = code;
    cmd_hl       = hl;
    cmd_src_xy   = xy;
    cmd_offset   = off;
    cmd_ret_addr = addr;
    cmd_len      = len;
    cmd_id       = id;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_ctrl);
      if (cmd_ready) begin
        tick();
        cmd_valid = 1'b0;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL cmd_accept: got no cmd_ready expected acceptance within 50 cycles");
    cmd_valid = 1'b0;
  endtask

  task automatic push_resp(input logic [31:0] data, input logic [10:0] id);
    cpu_resp_valid = 1'b1;
    cpu_resp_data  = data;
    cpu_resp_id    = id;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_ctrl);
      if (cpu_resp_ready) begin
        tick();
        cpu_resp_valid = 1'b0;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL resp_accept: got no cpu_resp_ready expected acceptance within 50 cycles");
    cpu_resp_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    check("drain_pending_beats", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    tick();
    tick();
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL global_timeout: got no finish expected finish before 200us");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1);
  end

  initial begin
    int nb;
    int accepted;

    // Reset values
    repeat (3) tick();
    @(negedge clk_ctrl);
    check("rst_tvalid", 32'(stream_out_TVALID), 32'd0);
    check("rst_tdata", stream_out_TDATA, 32'd0);
    check("rst_tlast", 32'(stream_out_TLAST), 32'd0);
    check("rst_tkeep", 32'(stream_out_TKEEP), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_cpu_resp_ready", 32'(cpu_resp_ready), 32'd0);
    check("rst_err_id", 32'(err_id), 32'd0);
    tick();
    clk_ctrl_rst_high = 1'b0;
    tick();

    // MSTORE short -> header + ACK beat, cmd_ready low two cycles
    stream_out_TREADY = 1'b1;
    expect_beat(32'h0200_0405, 1'b0);
    expect_beat(32'h0000_0000, 1'b1);
    send_cmd(3'd7, 1'b0, 6'h05, 12'h010, 32'h0, 16'd0, 11'd0);
    @(negedge clk_ctrl); check("mstore_ready_c1", 32'(cmd_ready), 32'd0);
    @(negedge clk_ctrl); check("mstore_ready_c2", 32'(cmd_ready), 32'd0);
    @(negedge clk_ctrl); check("mstore_ready_c3", 32'(cmd_ready), 32'd1);
    drain(20);

    // MLOAD long, len 4, pre-filled FIFO -> six back-to-back beats
    push_resp(32'hA, 11'd0);
    push_resp(32'hB, 11'd0);
    push_resp(32'hC, 11'd0);
    push_resp(32'hD, 11'd0);
    expect_beat(32'h1400_0811, 1'b0);
    expect_beat(32'h8000_0000, 1'b0);
    expect_beat(32'h0000_000A, 1'b0);
    expect_beat(32'h0000_000B, 1'b0);
    expect_beat(32'h0000_000C, 1'b0);
    expect_beat(32'h0000_000D, 1'b1);
    send_cmd(3'd6, 1'b1, 6'h11, 12'h020, 32'h8000_0000, 16'd4, 11'd0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_ctrl);
      check("mload_burst_valid", 32'(stream_out_TVALID), 32'd1);
    end
    @(negedge clk_ctrl);
    check("mload_after_valid", 32'(stream_out_TVALID), 32'd0);
    drain(20);

    // MPUT -> no packet, cmd_ready stays high
    nb = n_beats;
    send_cmd(3'd4, 1'b1, 6'h07, 12'h123, 32'h4444_0000, 16'd3, 11'd0);
    repeat (4) begin
      @(negedge clk_ctrl);
      check("mput_tvalid", 32'(stream_out_TVALID), 32'd0);
      check("mput_cmd_ready", 32'(cmd_ready), 32'd1);
    end
    check("mput_beats", 32'(n_beats - nb), 32'd0);
    tick();

    // MGET short with TREADY toggling -> exactly 2 beats, stable under stall
    push_resp(32'h0000_0055, 11'd0);
    stream_out_TREADY = 1'b0;
    expect_beat(32'h0403_FFFF, 1'b0);
    expect_beat(32'h0000_0055, 1'b1);
    nb = n_beats;
    send_cmd(3'd5, 1'b0, 6'h3F, 12'hFFF, 32'hDEAD_BEEF, 16'd5, 11'd0);
    for (int k = 0; k < 12; k++) begin
      stream_out_TREADY = ~stream_out_TREADY;
      tick();
    end
    stream_out_TREADY = 1'b1;
    drain(20);
    check("mget_beats", 32'(n_beats - nb), 32'd2);

    // MLOAD long with len 0 -> treated as one data word
    push_resp(32'h0000_0066, 11'd0);
    expect_beat(32'h1400_00C2, 1'b0);
    expect_beat(32'h0000_0100, 1'b0);
    expect_beat(32'h0000_0066, 1'b1);
    send_cmd(3'd6, 1'b1, 6'h02, 12'h003, 32'h0000_0100, 16'd0, 11'd0);
    drain(20);

    // FIFO fill with TREADY=0: 8 accepted, then back-pressure
    stream_out_TREADY = 1'b0;
    accepted = 0;
    for (int i = 0; i < 10; i++) begin
      cpu_resp_valid = 1'b1;
      cpu_resp_data  = 32'h100 + 32'(i);
      cpu_resp_id    = 11'd0;
      @(negedge clk_ctrl);
      if (!cpu_resp_ready) break;
      tick();
      accepted++;
    end
    cpu_resp_valid = 1'b0;
    check("fill_accepted", 32'(accepted), 32'd8);
    check("fill_ready_low", 32'(cpu_resp_ready), 32'd0);
    tick();
    stream_out_TREADY = 1'b1;
    expect_beat(32'h1400_0041, 1'b0);
    expect_beat(32'h1234_5678, 1'b0);
    for (int i = 0; i < 10; i++) expect_beat(32'h100 + 32'(i), i == 9);
    send_cmd(3'd6, 1'b1, 6'h01, 12'h001, 32'h1234_5678, 16'd10, 11'd0);
    push_resp(32'h108, 11'd0);
    push_resp(32'h109, 11'd0);
    drain(40);

    // ID mismatch: cmd_id 3, response id 4
    push_resp(32'h0000_0077, 11'd4);
    expect_beat(32'h0400_0002, 1'b0);
    expect_beat(32'h0000_0077, 1'b1);
    send_cmd(3'd6, 1'b0, 6'h02, 12'h000, 32'h0, 16'd1, 11'd3);
    drain(20);
`ifdef MEM_MGR_ENC_ID_CHECK_EN
    check("err_id_set", 32'(err_id), 32'd1);
    repeat (3) tick();
    check("err_id_sticky", 32'(err_id), 32'd1);
`else
    check("err_id_tied", 32'(err_id), 32'd0);
`endif

    // Reset while waiting in DATA aborts the packet
    expect_beat(32'h1400_0000, 1'b0);
    expect_beat(32'hAAAA_0000, 1'b0);
    send_cmd(3'd6, 1'b1, 6'h00, 12'h000, 32'hAAAA_0000, 16'd3, 11'd0);
    drain(20);
    check("data_wait_tvalid", 32'(stream_out_TVALID), 32'd0);
    check("data_wait_cmd_ready", 32'(cmd_ready), 32'd0);
    clk_ctrl_rst_high = 1'b1;
    tick();
    clk_ctrl_rst_high = 1'b0;
    @(negedge clk_ctrl);
    check("abort_tvalid", 32'(stream_out_TVALID), 32'd0);
    check("abort_tdata", stream_out_TDATA, 32'd0);
    check("abort_tlast", 32'(stream_out_TLAST), 32'd0);
    check("abort_tkeep", 32'(stream_out_TKEEP), 32'd0);
    check("abort_err_id", 32'(err_id), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    tick();

    // Post-reset: data arriving early is held until DATA
    push_resp(32'h0000_0099, 11'd0);
    nb = n_beats;
    repeat (3) tick();
    check("early_data_held", 32'(n_beats - nb), 32'd0);
    expect_beat(32'h0400_0000, 1'b0);
    expect_beat(32'h0000_0099, 1'b1);
    send_cmd(3'd5, 1'b0, 6'h00, 12'h000, 32'h0, 16'd1, 11'd0);
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
